// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: byte substitution tables, round constants,
// GF(2^8) helpers, key-schedule steps and the decrypt FSM state encoding.
package aes_pkg;

    localparam int NB = 4;
    localparam int NK = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEY_EXP = 2'd1,
        ROUND   = 2'd2
    } aes_state_e;

    // Byte 0x00 sits in the most significant byte of each table.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (x & {8{b[i]}});
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // K(i) from K(i-1); word 0 is the most significant word.
    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0]  w;
        logic [127:0] n;
        n = 128'h0;
        w = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
        for (int i = 0; i < NK; i++) begin
            w = w ^ k[127 - 32*i -: 32];
            n[127 - 32*i -: 32] = w;
        end
        return n;
    endfunction

    // K(i-1) from K(i), where rc is the round constant that produced K(i).
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; last_round drops InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] shifted_s;
    logic [127:0] keyed_s;
    logic [127:0] mixed_s;

    // Row r rotates right by r columns; byte index is column*4 + row.
    always_comb begin
        shifted_s = 128'h0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted_s[127 - 8*(c*4 + r) -: 8] = state_in[127 - 8*((((c - r) + 4) % 4)*4 + r) -: 8];
            end
        end
    end

    // Substitute each byte and fold in the round key.
    always_comb begin
        keyed_s = 128'h0;
        for (int i = 0; i < 16; i++) begin
            keyed_s[127 - 8*i -: 8] = inv_sbox(shifted_s[127 - 8*i -: 8]) ^ round_key[127 - 8*i -: 8];
        end
    end

    // Column mixing and final-round bypass.
    always_comb begin
        mixed_s = 128'h0;
        for (int c = 0; c < NB; c++) begin
            mixed_s[127 - 32*c -: 32] = inv_mix_column(keyed_s[127 - 32*c -: 32]);
        end
        if (last_round) begin
            state_out = keyed_s;
        end else begin
            state_out = mixed_s;
        end
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then ten inverse
// rounds unwinding the schedule. Optional K10 cache under AES_DEC_KEY_CACHE_EN.
module aes_decrypt_core
    import aes_pkg::*;
#(
    parameter int KEY_LEN       = 128,
    parameter int DATA_LEN      = 128,
    parameter int NUMS_OF_ROUND = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_valid_in,
    input  logic [DATA_LEN-1:0] cipher_text,
    input  logic                key_valid_in,
    input  logic [KEY_LEN-1:0]  cipher_key,
    output logic                ready_out,
    output logic                data_valid_out,
    output logic [DATA_LEN-1:0] plain_text
);

    localparam logic [3:0] LAST_RND = 4'(NUMS_OF_ROUND);

    aes_state_e          state_r;
    aes_state_e          next_state_s;
    logic [DATA_LEN-1:0] blk_r;
    logic [KEY_LEN-1:0]  key_r;
    logic [3:0]          cnt_r;
    logic [DATA_LEN-1:0] plain_r;
    logic                valid_r;

    logic                ready_s;
    logic                accept_s;
    logic                cache_start_s;
    logic [KEY_LEN-1:0]  cache_key_s;
    logic [KEY_LEN-1:0]  fwd_key_s;
    logic [KEY_LEN-1:0]  inv_key_s;
    logic                last_round_s;
    logic [DATA_LEN-1:0] round_out_s;

    assign accept_s = ready_s & data_valid_in & key_valid_in;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [KEY_LEN-1:0] k10_cache_r;
    logic               key_cached_r;

    assign cache_start_s = ready_s & data_valid_in & ~key_valid_in & key_cached_r;
    assign cache_key_s   = k10_cache_r;

    // Remember the final expanded key of the most recent full expansion.
    always_ff @(posedge clk) begin
        if (reset) begin
            k10_cache_r  <= 128'h0;
            key_cached_r <= 1'b0;
        end else if (state_r == KEY_EXP && cnt_r == LAST_RND) begin
            k10_cache_r  <= fwd_key_s;
            key_cached_r <= 1'b1;
        end
    end
`else
    assign cache_start_s = 1'b0;
    assign cache_key_s   = 128'h0;
`endif

    // Key schedule step in both directions; rcon index follows the counter.
    always_comb begin
        fwd_key_s    = key_fwd(key_r, rcon(cnt_r));
        inv_key_s    = key_inv(key_r, rcon(cnt_r + 4'd1));
        last_round_s = (cnt_r == 4'd0);
    end

    aes_inv_round u_inv_round (
        .state_in   (blk_r),
        .round_key  (inv_key_s),
        .last_round (last_round_s),
        .state_out  (round_out_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = KEY_EXP;
                end else if (cache_start_s) begin
                    next_state_s = ROUND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            KEY_EXP: begin
                if (cnt_r == LAST_RND) begin
                    next_state_s = ROUND;
                end else begin
                    next_state_s = KEY_EXP;
                end
            end
            ROUND: begin
                if (last_round_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ROUND;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        case (state_r)
            IDLE:    ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Block, key and counter datapath plus the registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_r   <= 128'h0;
            key_r   <= 128'h0;
            cnt_r   <= 4'd0;
            plain_r <= 128'h0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        blk_r <= cipher_text;
                        key_r <= cipher_key;
                        cnt_r <= 4'd1;
                    end else if (cache_start_s) begin
                        blk_r <= cipher_text ^ cache_key_s;
                        key_r <= cache_key_s;
                        cnt_r <= LAST_RND - 4'd1;
                    end
                end
                KEY_EXP: begin
                    key_r <= fwd_key_s;
                    if (cnt_r == LAST_RND) begin
                        blk_r <= blk_r ^ fwd_key_s;
                        cnt_r <= LAST_RND - 4'd1;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ROUND: begin
                    key_r <= inv_key_s;
                    if (last_round_s) begin
                        plain_r <= round_out_s;
                        valid_r <= 1'b1;
                    end else begin
                        blk_r <= round_out_s;
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign ready_out      = ready_s;
    assign data_valid_out = valid_r;
    assign plain_text     = plain_r;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core using the FIPS-197 reference vectors.
module tb_aes_decrypt_core;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam logic CACHE = 1'b1;
`else
    localparam logic CACHE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         dvi;
    logic         kvi;
    logic [127:0] ct;
    logic [127:0] key;
    logic         ready;
    logic         dvo;
    logic [127:0] pt;

    typedef struct {
        logic [127:0] pt;
        int           e0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vcyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    aes_decrypt_core dut (
        .clk            (clk),
        .reset          (reset),
        .data_valid_in  (dvi),
        .cipher_text    (ct),
        .key_valid_in   (kvi),
        .cipher_key     (key),
        .ready_out      (ready),
        .data_valid_out (dvo),
        .plain_text     (pt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every result pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && dvo) begin
            vcyc.push_back(cyc);
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", {127'd0, dvo}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("plain_text", pt, e.pt);
                check_eq("latency", 128'(cyc - e.e0), 128'(e.lat));
            end
        end
    end

    // Drive one cycle of request inputs at a negedge, then scramble them.
    task automatic drive(input logic [127:0] c, input logic [127:0] k, input logic dv, input logic kv,
                         input logic exp_ready, input logic push, input logic [127:0] exp_pt, input int lat);
        check_eq("ready_at_drive", {127'd0, ready}, {127'd0, exp_ready});
        ct  = c;
        key = k;
        dvi = dv;
        kvi = kv;
        if (push) sb.push_back('{exp_pt, cyc + 1, lat});
        @(negedge clk);
        dvi = 1'b0;
        kvi = 1'b0;
        ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    initial begin
        reset = 1'b1;
        dvi   = 1'b0;
        kvi   = 1'b0;
        ct    = 128'h0;
        key   = 128'h0;
        repeat (2) @(negedge clk);
        check_eq("reset_ready", {127'd0, ready}, 128'd1);
        check_eq("reset_valid", {127'd0, dvo}, 128'd0);
        check_eq("reset_plain", pt, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        // Two requests back to back.
        drive(CT_A, KEY_A, 1'b1, 1'b1, 1'b1, 1'b1, PT_A, 20);
        repeat (20) @(negedge clk);
        drive(CT_B, KEY_B, 1'b1, 1'b1, 1'b1, 1'b1, PT_B, 20);
        repeat (21) @(negedge clk);
        if (vcyc.size() >= 2) check_eq("b2b_gap", 128'(vcyc[1] - vcyc[0]), 128'd21);
        else check_eq("b2b_count", 128'(vcyc.size()), 128'd2);
        check_eq("hold_plain", pt, PT_B);
        check_eq("idle_ready", {127'd0, ready}, 128'd1);

        // Half-valid requests: key alone is ignored; data alone only uses the cache.
        drive(128'h0, KEY_B, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0, 0);
        drive(CT_B, 128'h0, 1'b1, 1'b0, 1'b1, CACHE, PT_B, 10);
        repeat (25) @(negedge clk);
        check_eq("hold_plain_partial", pt, PT_B);

        // All-zero key; a request while busy is dropped.
        drive(CT_C, 128'h0, 1'b1, 1'b1, 1'b1, 1'b1, 128'h0, 20);
        repeat (4) @(negedge clk);
        drive(CT_A, KEY_A, 1'b1, 1'b1, 1'b0, 1'b0, 128'h0, 0);
        repeat (20) @(negedge clk);
        check_eq("zero_key_plain", pt, 128'h0);

        drive(CT_A, KEY_A, 1'b1, 1'b1, 1'b1, 1'b1, PT_A, 20);
        repeat (21) @(negedge clk);
        check_eq("hold_plain_a", pt, PT_A);

        // Reset mid-operation: aborts without a result pulse.
        drive(CT_B, KEY_B, 1'b1, 1'b1, 1'b1, 1'b1, PT_B, 20);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_ready", {127'd0, ready}, 128'd1);
        check_eq("abort_valid", {127'd0, dvo}, 128'd0);
        check_eq("abort_plain", pt, 128'h0);
        repeat (25) @(negedge clk);
        check_eq("abort_plain_late", pt, 128'h0);

        // Reset wins over a simultaneous accept.
        reset = 1'b1;
        ct    = CT_A;
        key   = KEY_A;
        dvi   = 1'b1;
        kvi   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dvi   = 1'b0;
        kvi   = 1'b0;
        check_eq("reset_over_accept", {127'd0, ready}, 128'd1);
        repeat (25) @(negedge clk);

        // Recovery after reset.
        drive(CT_B, KEY_B, 1'b1, 1'b1, 1'b1, 1'b1, PT_B, 20);
        repeat (21) @(negedge clk);
        check_eq("pending", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
